echo_processor: RTL

Parametrised successor to the single-tap echo block in the ADC→DAC audio loop. It stores incoming sample-rate samples in a circular buffer and mixes in a delayed sample with programmable delay and gain. It supports bypass, feed-forward echo and feedback (recursive) echo modes, with saturating arithmetic. It sits between spi2adc (data_in/data_valid) and spi2dac/pwm (data_out), clocked by the 50 MHz sysclk.

---
 rtl/echo_processor.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/echo_processor.sv
// Echo processor: circular sample buffer with a programmable delayed tap,
// mixed back into the signal with saturating gain. Supports bypass,
// feed-forward echo and feedback (recursive) echo.
module echo_processor #(
  parameter int unsigned DW         = 10,
  parameter int unsigned AW         = 13,
  parameter int unsigned GAIN_W     = 4,
  parameter int unsigned GAIN_SHIFT = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              data_valid,
  input  logic [DW-1:0]     data_in,
  input  logic [1:0]        mode,
  input  logic [AW-1:0]     delay,
  input  logic [GAIN_W-1:0] gain,
  output logic [DW-1:0]     data_out,
  output logic              out_valid,
  output logic              overrun
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned FW    = AW + 1;
  localparam int unsigned SW    = DW + GAIN_W + 1;
  localparam int          SMAX  = (1 << (DW - 1)) - 1;
  localparam int          SMIN  = -(1 << (DW - 1));

  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  localparam logic [1:0] M_ECHO = 2'b01;
  localparam logic [1:0] M_FB   = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [DW-1:0]     din_q, din_d;
  logic [1:0]        mode_q, mode_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [AW-1:0]     dly_q, dly_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic              ovalid_q, ovalid_d;
  logic              ovr_q, ovr_d;

  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     ram_q;

  logic [AW-1:0]     eff_dly_c;
  logic [AW-1:0]     rd_addr_c;
  logic              rd_en_c;
  logic              we_c;
  logic [DW-1:0]     wdata_c;
  logic [DW-1:0]     y_out_c;

  logic signed [DW-1:0] x_c, d_c, y_c;
  logic signed [SW-1:0] g_c, prod_c, p_c, s_c;

  // Zero delay would read the slot about to be written; clamp to one sample.
  always_comb begin
    eff_dly_c = (delay == '0) ? AW'(1) : delay;
    rd_addr_c = wr_ptr_q - eff_dly_c;
  end

  // Signed mix: centre samples, scale the tap, add and clamp to the DW range.
  always_comb begin
    x_c = $signed({~din_q[DW-1], din_q[DW-2:0]});
    if (fill_q < {1'b0, dly_q}) begin
      d_c = '0;
    end else begin
      d_c = $signed({~ram_q[DW-1], ram_q[DW-2:0]});
    end
    g_c    = SW'($signed({1'b0, gain_q}));
    prod_c = SW'(d_c) * g_c;
    p_c    = prod_c >>> GAIN_SHIFT;
    s_c    = SW'(x_c) + p_c;
    if (s_c > SW'(SMAX)) begin
      y_c = DW'(SMAX);
    end else if (s_c < SW'(SMIN)) begin
      y_c = DW'(SMIN);
    end else begin
      y_c = s_c[DW-1:0];
    end
    if (mode_q != M_ECHO && mode_q != M_FB) begin
      y_c = x_c;
    end
    y_out_c = {~y_c[DW-1], y_c[DW-2:0]};
  end

  // Next-state and datapath control for IDLE -> RD -> CALC -> WR.
  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    mode_d   = mode_q;
    gain_d   = gain_q;
    dly_d    = dly_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    dout_d   = dout_q;
    ovalid_d = 1'b0;
    ovr_d    = 1'b0;
    rd_en_c  = 1'b0;
    we_c     = 1'b0;
    wdata_c  = (mode_q == M_FB) ? dout_q : din_q;
    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          din_d   = data_in;
          mode_d  = mode;
          gain_d  = gain;
          dly_d   = eff_dly_c;
          rd_en_c = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: begin
        ovr_d   = data_valid;
        state_d = S_CALC;
      end
      S_CALC: begin
        ovr_d    = data_valid;
        dout_d   = y_out_c;
        ovalid_d = 1'b1;
        state_d  = S_WR;
      end
      S_WR: begin
        ovr_d    = data_valid;
        we_c     = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        fill_d   = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + FW'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      din_q    <= MID;
      mode_q   <= 2'b00;
      gain_q   <= '0;
      dly_q    <= AW'(1);
      wr_ptr_q <= '0;
      fill_q   <= '0;
      dout_q   <= MID;
      ovalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      mode_q   <= mode_d;
      gain_q   <= gain_d;
      dly_q    <= dly_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      dout_q   <= dout_d;
      ovalid_q <= ovalid_d;
      ovr_q    <= ovr_d;
    end
  end

  // Sample buffer: synchronous write in WR, synchronous read on accept.
  always_ff @(posedge sysclk) begin
    if (we_c) begin
      mem[wr_ptr_q] <= wdata_c;
    end
    if (rd_en_c) begin
      ram_q <= mem[rd_addr_c];
    end
  end

  assign data_out  = dout_q;
  assign out_valid = ovalid_q;
  assign overrun   = ovr_q;

endmodule
